// File: rtl/array_ser_pkg.sv
// Shared definitions for the array serializer.
// Holds the controller state type and the default array geometry
// used by the interface and the top module.
package array_ser_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_WIDTH = 2;

    // IDLE: holding no data. SEND: holding a captured array.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/array_serializer_if.sv
// Load/stream interface of the array serializer.
//   in_valid / in_ready / in_arr  : array load handshake
//   out_valid / out_ready         : element stream handshake
//   out_data / out_idx / out_last : current element, its index, end-of-array flag
// The slave modport is the serializer side. The master modport is the
// producer/consumer side.
interface array_serializer_if
    import array_ser_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_arr [DEPTH-1:0];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output in_valid,
        output in_arr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_arr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_idx,
        output out_last
    );

endinterface

// File: rtl/array_elem_mux.sv
// Combinational element selector.
//   arr_i  : unpacked array of DEPTH elements, WIDTH bits each
//   idx_i  : element index
//   elem_o : arr_i[idx_i]. This is zero for an index outside 0..DEPTH-1.
module array_elem_mux #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0] arr_i [DEPTH-1:0],
    input  logic [IDX_W-1:0] idx_i,
    output logic [WIDTH-1:0] elem_o
);

    // An explicit compare loop keeps the select in range for
    // non-power-of-two DEPTH without relying on out-of-bounds indexing.
    always_comb begin
        elem_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_i == IDX_W'(i)) begin
                elem_o = arr_i[i];
            end
        end
    end

endmodule

// File: rtl/array_serializer.sv
// Array serializer.
// It captures an unpacked array of DEPTH elements in one handshake and then
// streams the elements out one per accepted beat.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : array_serializer_if slave (load handshake in, element stream out)
// With MSB_FIRST = 0, element 0 is sent first. With MSB_FIRST = 1,
// element DEPTH-1 is sent first.
module array_serializer
    import array_ser_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    array_serializer_if.slave   bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(DEPTH - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] arr_q [DEPTH-1:0];
    logic [WIDTH-1:0] arr_d [DEPTH-1:0];

    logic             sending;
    logic             is_last;
    logic             accept;
    logic             in_ready;
    logic             load;
    logic [WIDTH-1:0] elem;

    assign sending = (state_q == SEND);
    assign is_last = sending && (ptr_q == LAST_IDX);
    assign accept  = sending && bus.out_ready;

    // A new array is taken on the final accepted beat so that arrays stream
    // back to back. The gating on rst keeps in_ready low while in reset.
    assign in_ready = !rst && (!sending || (accept && is_last));
    assign load     = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        arr_d   = arr_q;

        if (accept) begin
            if (is_last) begin
                state_d = IDLE;
            end else if (MSB_FIRST) begin
                ptr_d = ptr_q - IDX_W'(1);
            end else begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end

        // A load takes priority over the return to IDLE on a final beat.
        if (load) begin
            state_d = SEND;
            ptr_d   = FIRST_IDX;
            arr_d   = bus.in_arr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            arr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            arr_q   <= arr_d;
        end
    end

    array_elem_mux #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_elem_mux (
        .arr_i  (arr_q),
        .idx_i  (ptr_q),
        .elem_o (elem)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = sending;
    assign bus.out_data  = elem;
    assign bus.out_idx   = ptr_q;
    assign bus.out_last  = is_last;

endmodule

// File: tb/tb_array_serializer.sv
// Self-checking bench for array_serializer.
// It runs three instances side by side:
//   inst0: DEPTH 4, WIDTH 2, LSB first
//   inst1: DEPTH 4, WIDTH 2, MSB first
//   inst2: DEPTH 3, WIDTH 1, LSB first
// The reference model is a queue of expected beats per instance. A load
// pushes the whole array in send order, and an accepted beat pops one entry.
module tb_array_serializer;

    typedef struct {
        int data;
        int idx;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    array_serializer_if #(.DEPTH(4), .WIDTH(2)) bus_a ();
    array_serializer_if #(.DEPTH(4), .WIDTH(2)) bus_b ();
    array_serializer_if #(.DEPTH(3), .WIDTH(1)) bus_c ();

    array_serializer #(.DEPTH(4), .WIDTH(2), .MSB_FIRST(1'b0)) u_dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    array_serializer #(.DEPTH(4), .WIDTH(2), .MSB_FIRST(1'b1)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    array_serializer #(.DEPTH(3), .WIDTH(1), .MSB_FIRST(1'b0)) u_dut_c (
        .clk (clk), .rst (rst), .bus (bus_c)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];
    bit    iv  [3];
    bit    rdy [3];
    int    ina [3][4];

    function automatic int depth_of(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit msb_of(int k);
        return k == 1;
    endfunction

    function automatic int mask_of(int k);
        return (k == 2) ? 1 : 3;
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic beat_t qfront(int k);
        case (k)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    // Ready when empty, or when the final element is being accepted now.
    function automatic bit mdl_in_ready(int k);
        if (rst) return 1'b0;
        return (qsize(k) == 0) || (qsize(k) == 1 && rdy[k]);
    endfunction

    // Packed as {in_ready, out_valid, out_last, idx[7:0], data[31:0]}.
    function automatic logic [42:0] exp_vec(int k);
        beat_t b;
        if (qsize(k) == 0) return {mdl_in_ready(k), 1'b0, 1'b0, 8'd0, 32'd0};
        b = qfront(k);
        return {mdl_in_ready(k), 1'b1, b.last, 8'(b.idx), 32'(b.data)};
    endfunction

    function automatic logic [42:0] obs_raw(int k);
        case (k)
            0: return {bus_a.in_ready, bus_a.out_valid, bus_a.out_last,
                       8'(bus_a.out_idx), 32'(bus_a.out_data)};
            1: return {bus_b.in_ready, bus_b.out_valid, bus_b.out_last,
                       8'(bus_b.out_idx), 32'(bus_b.out_data)};
            default: return {bus_c.in_ready, bus_c.out_valid, bus_c.out_last,
                             8'(bus_c.out_idx), 32'(bus_c.out_data)};
        endcase
    endfunction

    // Data and idx carry no meaning while out_valid is low.
    function automatic logic [42:0] obs_vec(int k);
        logic [42:0] v;
        v = obs_raw(k);
        if (v[41] !== 1'b1) v[39:0] = '0;
        return v;
    endfunction

    task automatic drive();
        bus_a.in_valid  = iv[0];
        bus_a.out_ready = rdy[0];
        bus_b.in_valid  = iv[1];
        bus_b.out_ready = rdy[1];
        bus_c.in_valid  = iv[2];
        bus_c.out_ready = rdy[2];
        for (int i = 0; i < 4; i++) begin
            bus_a.in_arr[i] = 2'(ina[0][i]);
            bus_b.in_arr[i] = 2'(ina[1][i]);
        end
        for (int i = 0; i < 3; i++) bus_c.in_arr[i] = 1'(ina[2][i]);
        #1;
    endtask

    task automatic push_beat(int k, beat_t b);
        case (k)
            0:       qa.push_back(b);
            1:       qb.push_back(b);
            default: qc.push_back(b);
        endcase
    endtask

    task automatic pop_beat(int k);
        beat_t b;
        case (k)
            0:       b = qa.pop_front();
            1:       b = qb.pop_front();
            default: b = qc.pop_front();
        endcase
    endtask

    // Apply this cycle's handshakes to the model, then move to the next cycle.
    task automatic advance();
        bit    acc [3];
        bit    ld  [3];
        beat_t b;
        int    d;
        for (int k = 0; k < 3; k++) begin
            acc[k] = (qsize(k) > 0) && rdy[k];
            ld[k]  = iv[k] && mdl_in_ready(k);
        end
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) pop_beat(k);
            if (ld[k]) begin
                d = depth_of(k);
                for (int j = 0; j < d; j++) begin
                    b.idx  = msb_of(k) ? d - 1 - j : j;
                    b.data = ina[k][b.idx] & mask_of(k);
                    b.last = (j == d - 1);
                    push_beat(k, b);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            iv[k]  = 1'b0;
            rdy[k] = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [42:0] o;
        idle_all();
        for (int k = 0; k < 3; k++) iv[k] = 1'b1;
        rst = 1'b1;
        qa.delete(); qb.delete(); qc.delete();
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            drive();
            for (int k = 0; k < 3; k++) begin
                o = obs_raw(k);
                vectors++;
                if (o !== 43'd0) begin
                    miscompares++;
                    $display("FAIL reset inst%0d t=%0t rdy/vld/last/idx/data got %0b/%0b/%0b/%0d/%0d want all 0",
                             k, $time, o[42], o[41], o[40], o[39:32], o[31:0]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        idle_all();
        drive();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_vec(k) !== exp_vec(k)) begin
                miscompares++;
                $display("FAIL reset_release inst%0d t=%0t got %h want %h",
                         k, $time, obs_vec(k), exp_vec(k));
            end
        end
        advance();
    endtask

    // Load arrays into the selected instances, then let them drain with the given ready pattern.
    task automatic test_stream(string name, bit use_a, bit use_b, bit use_c,
                               bit stall, bit b2b);
        bit pat [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            ina[0][i] = i;
            ina[1][i] = i;
        end
        for (int i = 0; i < 3; i++) ina[2][i] = int'($urandom_range(0, 1));
        idle_all();
        iv[0] = use_a;
        iv[1] = use_b;
        iv[2] = use_c;
        for (int cyc = 0; cyc < 14; cyc++) begin
            drive();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL %s inst%0d cyc %0d got rdy/vld/last/idx/data %0b/%0b/%0b/%0d/%0d want %0b/%0b/%0b/%0d/%0d",
                             name, k, cyc, obs_vec(k) >> 42, obs_vec(k) >> 41 & 1,
                             obs_vec(k) >> 40 & 1, obs_vec(k) >> 32 & 8'hff,
                             obs_vec(k) & 32'hffff_ffff, exp_vec(k) >> 42,
                             exp_vec(k) >> 41 & 1, exp_vec(k) >> 40 & 1,
                             exp_vec(k) >> 32 & 8'hff, exp_vec(k) & 32'hffff_ffff);
                end
            end
            if (use_c) begin
                vectors++;
                if (bus_c.out_valid === 1'b1 && bus_c.out_idx === 2'd3) begin
                    miscompares++;
                    $display("FAIL %s idx_range got idx 3 want 0..2", name);
                end
            end
            advance();
            idle_all();
            if (stall && cyc < 8) rdy[0] = pat[cyc];
            // The cycle after loading, cycles 1..4 show beats 0..3. Offer the
            // next array while the final beat is shown.
            if (b2b && cyc == 3) begin
                iv[0] = 1'b1;
                ina[0] = '{0, 0, 1, 1};
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [42:0] o;
        idle_all();
        for (int i = 0; i < 4; i++) ina[0][i] = int'($urandom_range(0, 3));
        iv[0] = 1'b1;
        drive();
        advance();
        idle_all();
        for (int n = 0; n < 3; n++) begin
            drive();
            vectors++;
            if (obs_vec(0) !== exp_vec(0)) begin
                miscompares++;
                $display("FAIL reset_mid_pre cyc %0d got %h want %h", n, obs_vec(0), exp_vec(0));
            end
            if (n < 2) advance();
        end
        #1 rst = 1'b1;
        #1;
        o = obs_raw(0);
        vectors++;
        if (o[41] !== 1'b0 || o[40] !== 1'b0 || o[39:32] !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async got vld/last/idx %0b/%0b/%0d want 0/0/0",
                     o[41], o[40], o[39:32]);
        end
        qa.delete(); qb.delete(); qc.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ina[0][i] = 3 - i;
        iv[0] = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive();
            vectors++;
            if (obs_vec(0) !== exp_vec(0)) begin
                miscompares++;
                $display("FAIL reset_mid_restart cyc %0d got %h want %h",
                         cyc, obs_vec(0), exp_vec(0));
            end
            advance();
            iv[0] = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                iv[k]  = ($urandom_range(0, 1) == 1);
                rdy[k] = ($urandom_range(0, 9) < 7);
                for (int i = 0; i < 4; i++) ina[k][i] = int'($urandom_range(0, 3));
            end
            drive();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    miscompares++;
                    $display("FAIL random inst%0d cyc %0d got %h want %h",
                             k, cyc, obs_vec(k), exp_vec(k));
                end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        for (int k = 0; k < 3; k++) for (int i = 0; i < 4; i++) ina[k][i] = 0;
        test_reset();
        test_stream("lsb_first", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        test_stream("msb_first", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        test_stream("stall", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        test_stream("back_to_back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        test_stream("depth3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/array_serializer.md
ARRAY_SERIALIZER -- requirements
Module: array_serializer

Interface
REQ-001 Parameter DEPTH, default 4: number of elements in the unpacked input array; legal range 2..16.
REQ-002 Parameter WIDTH, default 2: bit width of each array element; legal range 1..32.
REQ-003 Parameter MSB_FIRST, default 0: 0 emits element index 0 first; 1 emits index DEPTH-1 first.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 in_valid  input  1: the in_arr contents are offered for loading.
REQ-007 in_ready  output  1: the block accepts a load this cycle.
REQ-008 in_arr  input  unpacked [DEPTH-1:0] of WIDTH bits: array to serialize.
REQ-009 out_valid  output  1: out_data holds a valid element.
REQ-010 out_ready  input  1: downstream accepts the current element.
REQ-011 out_data  output  WIDTH: current element.
REQ-012 out_idx  output  $clog2(DEPTH): array index of the current element.
REQ-013 out_last  output  1: current element is the final element of the array.

Function
REQ-014 The block SHALL have two states: IDLE (holding no data) and SEND (holding a captured array).
REQ-015 A load SHALL occur on any clock edge where in_valid && in_ready; the load captures all DEPTH elements of in_arr into an internal unpacked register array.
REQ-016 in_ready SHALL equal (state==IDLE) || (out_valid && out_ready && out_last), so back-to-back arrays stream with no idle cycle.
REQ-017 A load SHALL set the state to SEND and set the element pointer to 0 (MSB_FIRST=0) or DEPTH-1 (MSB_FIRST=1).
REQ-018 out_valid SHALL be 1 exactly when state==SEND; the first element SHALL appear in the cycle after the load (latency 1).
REQ-019 out_data SHALL equal the captured element at out_idx; out_idx SHALL equal the pointer.
REQ-020 out_last SHALL be 1 when out_valid is 1 and the pointer is DEPTH-1 (MSB_FIRST=0) or 0 (MSB_FIRST=1).
REQ-021 When out_valid && out_ready && !out_last, the pointer SHALL step by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
REQ-022 When out_valid && out_ready && out_last with no load, the state SHALL return to IDLE.
REQ-023 When out_valid && out_ready && out_last coincide with a load, the state SHALL remain SEND, the new array SHALL be captured, and the pointer SHALL reload.
REQ-024 When out_valid && !out_ready, out_data, out_idx and out_last SHALL remain stable until accepted.
REQ-025 Changes to in_arr while in SEND SHALL NOT affect the outputs; captured data is held.
REQ-026 The pointer SHALL never leave 0..DEPTH-1, including when DEPTH is not a power of two.

Reset
REQ-027 While rst is 1, the block SHALL be in IDLE with pointer 0, out_valid 0, out_last 0, out_data 0, out_idx 0 and in_ready 0.
REQ-028 Reset asserted mid-array SHALL discard the remaining elements; after rst deasserts, in_ready SHALL be 1 in the first cycle.
REQ-029 The captured array register SHALL reset to all zeros.

Structure
REQ-030 A shared package array_ser_pkg SHALL hold the state enum (IDLE, SEND) and the default DEPTH and WIDTH constants.
REQ-031 One sub-module, array_elem_mux, SHALL select the unpacked element by index (combinational); all sequencing SHALL live in array_serializer.

Verification
REQ-032 DEPTH=4, WIDTH=2, MSB_FIRST=0, in_arr='{3,2,1,0} loaded, out_ready=1 -> out_data 0,1,2,3 on four consecutive cycles; out_idx 0..3; out_last only on the 4th cycle.
REQ-033 Same array with MSB_FIRST=1 -> out_data 3,2,1,0; out_idx 3..0; out_last with idx 0.
REQ-034 out_ready held 0 for 3 cycles at idx 1 -> out_data=1 and idx=1 held stable; sequence resumes with 2,3 and no element is lost or duplicated.
REQ-035 Second array '{1,1,0,0} presented with in_valid during the last beat of the first -> in_ready=1 on that beat; the next cycle shows out_data=0, idx 0 with no gap.
REQ-036 rst pulsed while at idx 2 -> out_valid=0 immediately; a fresh load after release restarts at idx 0 with the new data.
REQ-037 DEPTH=3, WIDTH=1 -> idx runs 0,1,2 then returns to IDLE, and idx 3 is never observed.
